// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, index-width helper and the w_data reset value.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  localparam logic [7:0] W_DATA_RST = 8'h00;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned IDX_W(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Per-requester byte handshake bundle shared by all requesters.
// Requesters drive through master, the arbiter consumes through slave.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req searching
// ptr, ptr+1, ... modulo N. Usable by any shared-resource arbiter.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter write port among N_REQ
// byte requesters. Define UART_ARB_BURST_EN to allow MAX_BURST-byte grants.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_tx_arbiter_if.slave          rq,
  input  logic                      tx_full,
  output logic [7:0]                w_data,
  output logic                      wr_uart,
  output logic                      gnt_valid,
  output logic [IDX_W(N_REQ)-1:0]   gnt_id
);
  localparam int unsigned IW = IDX_W(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..8 and MAX_BURST 1..255");
  end

  arb_state_e    state;
  logic [IW-1:0] ptr;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          accept_idle;
  logic          accept_cont;
  logic [IW-1:0] sel;
  logic [7:0]    sel_byte;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (rq.req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign accept_idle = (state == IDLE) && !tx_full && pick_found;

`ifdef UART_ARB_BURST_EN
  logic [7:0] burst_cnt;
  // WAIT is the first cycle tx_full reflects the previous write, so it gates continuation.
  assign accept_cont = (state == WAIT) && rq.req_valid[gnt_id] && !tx_full &&
                       (burst_cnt < 8'(MAX_BURST));
`else
  assign accept_cont = 1'b0;
`endif

  assign sel      = accept_idle ? pick_idx : gnt_id;
  assign sel_byte = rq.req_data[{sel, 3'b000} +: 8];

  always_comb begin
    rq.req_ready = '0;
    if (accept_idle || accept_cont) rq.req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      w_data    <= W_DATA_RST;
      wr_uart   <= 1'b0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
`ifdef UART_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          wr_uart   <= 1'b0;
          gnt_valid <= 1'b0;
          if (accept_idle) begin
            w_data    <= sel_byte;
            gnt_id    <= pick_idx;
            wr_uart   <= 1'b1;
            gnt_valid <= 1'b1;
            state     <= ISSUE;
`ifdef UART_ARB_BURST_EN
            burst_cnt <= 8'd1;
`endif
          end
        end
        ISSUE: begin
          wr_uart <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (accept_cont) begin
            w_data  <= sel_byte;
            wr_uart <= 1'b1;
            state   <= ISSUE;
`ifdef UART_ARB_BURST_EN
            burst_cnt <= burst_cnt + 8'd1;
`endif
          end else begin
            ptr       <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a cycle-level reference model predicts
// grants and pushes expected writes; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned MAXB = 4;
  localparam int unsigned IW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_full = 1'b0;
  logic [7:0]    w_data;
  logic          wr_uart;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;

  uart_tx_arbiter_if #(.N_REQ(N)) rq ();

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rq        (rq),
    .tx_full   (tx_full),
    .w_data    (w_data),
    .wr_uart   (wr_uart),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]    data;
    logic [IW-1:0] id;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   neg_cnt = 0;
  bit   mon_en = 0;

  // Reference model: owner of the port (or none), cycles left in its slot,
  // rotation start point and bytes sent in the current grant.
  int             m_busy = 0;
  int             m_ptr  = 0;
  int             m_g    = 0;
  int             m_cnt  = 0;
  logic [N-1:0]   m_ready;
  bit             m_acc;
  bit             m_acc_cont;
  int             m_acc_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    neg_cnt++;
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].cyc < neg_cnt) begin
        mon_e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_write: got no strobe expected w_data=%02h at cycle %0d", mon_e.data, mon_e.cyc);
      end
      if (wr_uart !== 1'b0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_write: got wr_uart=%b w_data=%02h expected no write", wr_uart, w_data);
        end else begin
          mon_e = sb.pop_front();
          check("w_data", {24'd0, w_data}, {24'd0, mon_e.data});
          check("gnt_id", {30'd0, gnt_id}, {30'd0, mon_e.id});
          check("write_cycle", neg_cnt, mon_e.cyc);
        end
      end
    end
  end

  function automatic void model_comb(input logic [N-1:0] v, input logic full);
    m_ready    = '0;
    m_acc      = 0;
    m_acc_cont = 0;
    if (m_busy == 0 && !full) begin
      for (int k = 0; k < N; k++) begin
        if (!m_acc && v[(m_ptr + k) % N]) begin
          m_acc   = 1;
          m_acc_g = (m_ptr + k) % N;
        end
      end
    end
`ifdef UART_ARB_BURST_EN
    else if (m_busy == 1 && v[m_g] && !full && m_cnt < MAXB) begin
      m_acc      = 1;
      m_acc_cont = 1;
      m_acc_g    = m_g;
    end
`endif
    if (m_acc) m_ready[m_acc_g] = 1'b1;
  endfunction

  function automatic void model_edge(input logic [8*N-1:0] d);
    if (m_acc) begin
      sb.push_back('{data: d[8*m_acc_g +: 8], id: IW'(m_acc_g), cyc: neg_cnt + 1});
      m_cnt  = m_acc_cont ? m_cnt + 1 : 1;
      m_g    = m_acc_g;
      m_busy = 2;
    end else if (m_busy == 2) begin
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_ptr  = (m_g + 1) % N;
      m_busy = 0;
    end
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic full);
    @(negedge clk);
    rq.req_valid = v;
    rq.req_data  = d;
    tx_full      = full;
    #1;
    model_comb(v, full);
    check("req_ready", {28'd0, rq.req_ready}, {28'd0, m_ready});
    check("gnt_valid", {31'd0, gnt_valid}, {31'd0, (m_busy != 0)});
    @(posedge clk);
    model_edge(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rq.req_valid = '0;
    tx_full      = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    m_busy = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    @(negedge clk);
    #1;
    check("rst_w_data", {24'd0, w_data}, 32'h00);
    check("rst_wr_uart", {31'd0, wr_uart}, 32'h0);
    check("rst_gnt_valid", {31'd0, gnt_valid}, 32'h0);
    check("rst_gnt_id", {30'd0, gnt_id}, 32'h0);
    check("rst_req_ready", {28'd0, rq.req_ready}, 32'h0);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run expected completion within time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]   rv;
    logic [8*N-1:0] rd;
    int             i1;
    bit             got2;

    rq.req_valid = '0;
    rq.req_data  = '0;
    do_reset();
    mon_en = 1;

    // Single requester: byte A5 from index 2.
    step(4'b0100, 32'h00A5_0000, 1'b0);
    idle(4);

    // All valid, fixed bytes: strict rotation 00,11,22,33,00,...
    do_reset();
    for (int i = 0; i < 15; i++) step(4'b1111, 32'h3322_1100, 1'b0);
    idle(4);

    // tx_full holds off acceptance, then releases.
    for (int i = 0; i < 10; i++) step(4'b0001, 32'h0000_005C, 1'b1);
    step(4'b0001, 32'h0000_005C, 1'b0);
    idle(4);

`ifdef UART_ARB_BURST_EN
    // Burst stream on req1 interleaved with a single byte on req2.
    do_reset();
    i1   = 0;
    got2 = 0;
    for (int i = 0; i < 30; i++) begin
      rv    = '0;
      rd    = '0;
      rv[1] = (i1 < 6);
      rv[2] = !got2;
      rd[15:8]  = 8'h10 + 8'(i1);
      rd[23:16] = 8'h77;
      step(rv, rd, 1'b0);
      if (m_acc && m_acc_g == 1) i1++;
      if (m_acc && m_acc_g == 2) got2 = 1;
    end
    idle(4);
`endif

    // Reset landing in ISSUE, then lowest valid index from 0 wins.
    step(4'b0100, 32'h00C3_0000, 1'b0);
    step(4'b0100, 32'h00C3_0000, 1'b0);
    step(4'b0000, 32'h0000_0000, 1'b0);
    step(4'b0001, 32'h0000_0042, 1'b0);
    do_reset();
    step(4'b1010, 32'hBB00_AA00, 1'b0);
    idle(4);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        rv[r]        = ($urandom_range(0, 9) < 7);
        rd[8*r +: 8] = 8'($urandom);
      end
      step(rv, rd, ($urandom_range(0, 4) == 0));
    end
    idle(6);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
